// File: rtl/gray_fifo_ptr_ctrl_pkg.sv
// Shared defaults and Gray-code helpers for the FIFO pointer controller.
// Helpers work on a fixed wide vector so any pointer width up to GRAY_MAX_W can use them.
package gray_pkg;

    localparam int ADDR_W     = 3;
    localparam int PTR_W      = ADDR_W + 1;
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Full when the write Gray pointer equals the read one with its top two bits inverted.
    function automatic logic gray_full_cmp(input logic [GRAY_MAX_W-1:0] wr_g,
                                           input logic [GRAY_MAX_W-1:0] rd_g,
                                           input int                    ptr_w);
        logic [GRAY_MAX_W-1:0] mask_s;
        mask_s = {{(GRAY_MAX_W-2){1'b0}}, 2'b11} << (ptr_w - 2);
        return (wr_g == (rd_g ^ mask_s));
    endfunction

endpackage

// File: rtl/gray_fifo_ptr_ctrl_gray_ptr.sv
// Binary pointer with a registered Gray copy updated on the same edge.
// Exposes next-state values so flags can be registered in step with the pointers.
module gray_ptr
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_nxt,
    output logic [W-1:0] gray_nxt
);

    logic [W-1:0] bin_r;
    logic [W-1:0] gray_r;
    logic [W-1:0] bin_nxt_s;
    logic [W-1:0] gray_nxt_s;

    // Next pointer: clear has priority over increment.
    always_comb begin
        bin_nxt_s = bin_r;
        if (clr) begin
            bin_nxt_s = {W{1'b0}};
        end else if (inc) begin
            bin_nxt_s = bin_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            bin_nxt_s = bin_r;
        end
        gray_nxt_s = W'(bin2gray(GRAY_MAX_W'(bin_nxt_s)));
    end

    // Pointer registers; Gray is loaded from the same next value so it never lags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= {W{1'b0}};
            gray_r <= {W{1'b0}};
        end else begin
            bin_r  <= bin_nxt_s;
            gray_r <= gray_nxt_s;
        end
    end

    assign bin      = bin_r;
    assign gray     = gray_r;
    assign bin_nxt  = bin_nxt_s;
    assign gray_nxt = gray_nxt_s;

endmodule

// File: rtl/gray_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller: Gray write/read pointers, registered
// full/empty/count/almost_full flags and sticky overflow/underflow.
module gray_fifo_ptr_ctrl
    import gray_pkg::*;
#(
    parameter int ADDR_W   = gray_pkg::ADDR_W,
    parameter int AF_LEVEL = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                wr_req,
    input  logic                rd_req,
    input  logic                clr_err,
    output logic                wr_en,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [ADDR_W:0]     wr_ptr_gray,
    output logic [ADDR_W:0]     rd_ptr_gray,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic [ADDR_W:0]     count,
    output logic                overflow,
    output logic                underflow
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wr_bin_s, wr_gray_s, wr_bin_nxt_s, wr_gray_nxt_s;
    logic [PTR_W-1:0] rd_bin_s, rd_gray_s, rd_bin_nxt_s, rd_gray_nxt_s;
    logic [PTR_W-1:0] count_r, count_nxt_s;
    logic             full_r, empty_r, af_r, ovf_r, unf_r;
    logic             full_nxt_s, empty_nxt_s, af_nxt_s, ovf_nxt_s, unf_nxt_s;
    logic             wr_acc_s, rd_acc_s;

    assign wr_acc_s = wr_req & ~full_r & ~flush;
    assign rd_acc_s = rd_req & ~empty_r & ~flush;

    gray_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .inc      (wr_acc_s),
        .bin      (wr_bin_s),
        .gray     (wr_gray_s),
        .bin_nxt  (wr_bin_nxt_s),
        .gray_nxt (wr_gray_nxt_s)
    );

    gray_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .inc      (rd_acc_s),
        .bin      (rd_bin_s),
        .gray     (rd_gray_s),
        .bin_nxt  (rd_bin_nxt_s),
        .gray_nxt (rd_gray_nxt_s)
    );

    // Flags and occupancy from next-state pointers; a flush zeroes both pointers so empty follows.
    always_comb begin
        count_nxt_s = wr_bin_nxt_s - rd_bin_nxt_s;
        empty_nxt_s = (wr_gray_nxt_s == rd_gray_nxt_s);
        full_nxt_s  = gray_full_cmp(GRAY_MAX_W'(wr_gray_nxt_s), GRAY_MAX_W'(rd_gray_nxt_s), PTR_W);
        af_nxt_s    = (count_nxt_s >= PTR_W'(AF_LEVEL));
    end

    // Sticky errors: flush clears, a new error beats clr_err.
    always_comb begin
        ovf_nxt_s = ovf_r;
        unf_nxt_s = unf_r;
        if (flush) begin
            ovf_nxt_s = 1'b0;
            unf_nxt_s = 1'b0;
        end else begin
            if (wr_req & full_r) begin
                ovf_nxt_s = 1'b1;
            end else if (clr_err) begin
                ovf_nxt_s = 1'b0;
            end else begin
                ovf_nxt_s = ovf_r;
            end
            if (rd_req & empty_r) begin
                unf_nxt_s = 1'b1;
            end else if (clr_err) begin
                unf_nxt_s = 1'b0;
            end else begin
                unf_nxt_s = unf_r;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {PTR_W{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            full_r  <= full_nxt_s;
            empty_r <= empty_nxt_s;
            af_r    <= af_nxt_s;
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

    assign wr_en       = wr_acc_s;
    assign rd_en       = rd_acc_s;
    assign wr_addr     = wr_bin_s[ADDR_W-1:0];
    assign rd_addr     = rd_bin_s[ADDR_W-1:0];
    assign wr_ptr_gray = wr_gray_s;
    assign rd_ptr_gray = rd_gray_s;
    assign count       = count_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign almost_full = af_r;
    assign overflow    = ovf_r;
    assign underflow   = unf_r;

endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against an occupancy model.
module tb_gray_fifo_ptr_ctrl;

    localparam int DEPTH = 8;
    localparam int PMOD  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, wr_req = 1'b0, rd_req = 1'b0, clr_err = 1'b0;
    logic       wr_en, rd_en, full, empty, almost_full, overflow, underflow;
    logic [2:0] wr_addr, rd_addr;
    logic [3:0] wr_ptr_gray, rd_ptr_gray, count;

    int checks = 0;
    int errors = 0;

    // model: free-running write/read totals modulo 2*DEPTH
    int mwb = 0, mrb = 0;
    bit movf = 0, munf = 0;

    gray_fifo_ptr_ctrl #(.ADDR_W(3), .AF_LEVEL(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wr_req), .rd_req(rd_req),
        .clr_err(clr_err), .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr),
        .rd_addr(rd_addr), .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
        .full(full), .empty(empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic int occ();
        return (mwb - mrb + PMOD) % PMOD;
    endfunction

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs();
        chk("wr_ptr_gray", int'(wr_ptr_gray), gray_of(mwb));
        chk("rd_ptr_gray", int'(rd_ptr_gray), gray_of(mrb));
        chk("count", int'(count), occ());
        chk("full", int'(full), int'(occ() == DEPTH));
        chk("empty", int'(empty), int'(occ() == 0));
        chk("almost_full", int'(almost_full), int'(occ() >= 6));
        chk("overflow", int'(overflow), int'(movf));
        chk("underflow", int'(underflow), int'(munf));
    endtask

    task automatic cycle(input bit w, input bit r, input bit f, input bit c);
        bit ew, er, mfull, mempty;
        @(negedge clk);
        wr_req = w; rd_req = r; flush = f; clr_err = c;
        mfull  = (occ() == DEPTH);
        mempty = (occ() == 0);
        ew = w && !mfull && !f;
        er = r && !mempty && !f;
        #1;
        chk("wr_en", int'(wr_en), int'(ew));
        chk("rd_en", int'(rd_en), int'(er));
        chk("wr_addr", int'(wr_addr), mwb % DEPTH);
        chk("rd_addr", int'(rd_addr), mrb % DEPTH);
        @(posedge clk);
        if (f) begin
            mwb = 0; mrb = 0; movf = 0; munf = 0;
        end else begin
            if (w && mfull) movf = 1; else if (c) movf = 0;
            if (r && mempty) munf = 1; else if (c) munf = 0;
            if (ew) mwb = (mwb + 1) % PMOD;
            if (er) mrb = (mrb + 1) % PMOD;
        end
        #1;
        check_regs();
    endtask

    logic [3:0] gseq [8];

    initial begin
        gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        #13 rst_n = 1'b1;
        #1;
        // reset state, literal
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_wgray", int'(wr_ptr_gray), 0);
        chk("rst_rgray", int'(rd_ptr_gray), 0);
        cycle(0, 0, 0, 0);

        // fill: Gray sequence and almost_full pinned by literals
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0, 0);
            chk("gray_seq", int'(wr_ptr_gray), int'(gseq[i]));
            chk("af_lit", int'(almost_full), (i + 1 >= 6) ? 1 : 0);
        end
        chk("full_lit", int'(full), 1);
        chk("count8_lit", int'(count), 8);

        // full with both requests: only the read goes
        cycle(1, 1, 0, 0);
        chk("both_full_count", int'(count), 7);
        chk("both_full_full", int'(full), 0);
        chk("ovf_lit", int'(overflow), 1);

        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0);
        chk("drained_empty", int'(empty), 1);
        cycle(0, 1, 0, 0);
        chk("unf_lit", int'(underflow), 1);
        cycle(0, 0, 0, 0);
        chk("unf_sticky", int'(underflow), 1);
        cycle(0, 0, 0, 1);
        chk("unf_clr", int'(underflow), 0);
        chk("ovf_clr", int'(overflow), 0);

        // wrap with one item in flight
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 0, 0);
            chk("wrap_count", int'(count), 1);
        end
        cycle(0, 1, 0, 0);
        chk("wrap_empty", int'(empty), 1);

        // flush at half full beats a write
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        chk("half_count", int'(count), 4);
        cycle(1, 0, 1, 0);
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_wgray", int'(wr_ptr_gray), 0);
        chk("flush_rgray", int'(rd_ptr_gray), 0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        @(negedge clk);
        wr_req = 1'b0; flush = 1'b0; rd_req = 1'b0; clr_err = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_wgray", int'(wr_ptr_gray), 0);
        chk("arst_waddr", int'(wr_addr), 0);
        mwb = 0; mrb = 0; movf = 0; munf = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
